exec_unit: RTL and testbench

- Parametrised execute stage; successor to the single-cycle ALU/controller pair.
- Takes a decoded operation, two XLEN-bit operands and a destination tag through a valid/ready handshake.
- Returns the result with the same tag through a second valid/ready handshake.
- RV32I register ALU ops finish in one cycle; RV32M multiply/divide ops run on an iterative shift-add/restoring datapath.
- Sits between decode/register-read and writeback.

---
 rtl/exec_pkg.sv | 37 +++
 rtl/muldiv_iter.sv | 116 +++++++++++
 rtl/exec_unit.sv | 152 +++++++++++++++
 tb/tb_exec_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// exec_pkg: op-field encodings, FSM state type and decoded-op layout for the execute stage.
package exec_pkg;

   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_SLTU   = 3'b011;
   localparam logic [2:0] F3_XOR    = 3'b100;
   localparam logic [2:0] F3_SR     = 3'b101;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic       is_m;
      logic       f7b5;
      logic [2:0] funct3;
   } op_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// muldiv_iter: XLEN-step shift-add multiplier / restoring divider on operand magnitudes,
// followed by one FIX cycle that applies the result sign and selects the half.
module muldiv_iter
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            res_i,
   input  logic            i_flush,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_last,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN);

   logic              r_run;
   logic              r_fix;
   logic              r_neg;
   logic [2:0]        r_f3;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_b;

   logic              w_sgn_a;
   logic              w_sgn_b;
   logic              w_neg_a;
   logic              w_neg_b;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shift;
   logic              w_ge;
   logic [XLEN-1:0]   w_rem_nx;
   logic [2*XLEN-1:0] w_prod;

   assign w_sgn_a = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                    (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
   assign w_sgn_b = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
   assign w_neg_a = w_sgn_a & i_a[XLEN-1];
   assign w_neg_b = w_sgn_b & i_b[XLEN-1];
   assign w_mag_a = w_neg_a ? -i_a : i_a;
   assign w_mag_b = w_neg_b ? -i_b : i_b;

   // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
   assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
   assign w_shift  = {r_hi, r_lo[XLEN-1]};
   assign w_ge     = w_shift >= {1'b0, r_b};
   assign w_rem_nx = w_ge ? XLEN'(w_shift - {1'b0, r_b}) : w_shift[XLEN-1:0];

   always_ff @(posedge clk_i or negedge res_i) begin
      if (!res_i) begin
         r_run <= 1'b0;
         r_fix <= 1'b0;
         r_neg <= 1'b0;
         r_f3  <= '0;
         r_cnt <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_b   <= '0;
      end else if (i_flush) begin
         r_run <= 1'b0;
         r_fix <= 1'b0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_fix <= 1'b0;
         r_cnt <= CW'(XLEN-1);
         r_f3  <= i_funct3;
         r_neg <= (i_funct3 == F3_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);
         r_hi  <= '0;
         r_lo  <= w_mag_a;
         r_b   <= w_mag_b;
      end else if (r_run) begin
         if (r_f3[2]) begin
            r_hi <= w_rem_nx;
            r_lo <= {r_lo[XLEN-2:0], w_ge};
         end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
         end
         if (r_cnt == '0) begin
            r_run <= 1'b0;
            r_fix <= 1'b1;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end else begin
         r_fix <= 1'b0;
      end
   end

   assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};

   always_comb begin
      o_result = '0;
      case (r_f3)
         F3_MUL:                        o_result = w_prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:               o_result = r_neg ? -r_lo : r_lo;
         default:                       o_result = r_neg ? -r_hi : r_hi;
      endcase
   end

   assign o_last = r_run & (r_cnt == '0);
   assign o_done = r_fix;

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// exec_unit: RV32I ALU + optional iterative RV32M execute stage with valid/ready in and out.
// Build macro EXEC_MULDIV_EN enables the multiply/divide datapath; otherwise M ops flag illeg_o.
module exec_unit
   import exec_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             res_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [4:0]       op_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             illeg_o,
   output logic             busy_o
);

   localparam int SW = $clog2(XLEN);

   state_t            r_state;
   logic [XLEN-1:0]   r_result;
   logic [TAG_W-1:0]  r_tag;
   logic              r_illeg;

   op_t               w_op;
   logic              w_accept;
   logic [SW-1:0]     w_shamt;
   logic [XLEN-1:0]   w_sra;
   logic [XLEN-1:0]   w_alu;

   assign w_op       = op_t'(op_i);
   assign in_ready_o = (r_state == S_IDLE) & ~flush_i;
   assign w_accept   = in_valid_i & in_ready_o;
   assign w_shamt    = b_i[SW-1:0];
   // Kept separate so the ternary below cannot strip the signedness of the shift.
   assign w_sra      = $signed(a_i) >>> w_shamt;

   always_comb begin
      w_alu = '0;
      case (w_op.funct3)
         F3_ADD:  w_alu = w_op.f7b5 ? (a_i - b_i) : (a_i + b_i);
         F3_SLL:  w_alu = a_i << w_shamt;
         F3_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         F3_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a_i < b_i)};
         F3_XOR:  w_alu = a_i ^ b_i;
         F3_SR:   w_alu = w_op.f7b5 ? w_sra : (a_i >> w_shamt);
         F3_OR:   w_alu = a_i | b_i;
         default: w_alu = a_i & b_i;
      endcase
   end

`ifdef EXEC_MULDIV_EN
   logic            w_b_zero;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_special_res;
   logic            w_md_last;
   logic            w_md_done;
   logic [XLEN-1:0] w_md_result;

   // Divide-by-zero and signed overflow bypass the iteration entirely.
   assign w_b_zero      = (b_i == '0);
   assign w_ovf         = ((w_op.funct3 == F3_DIV) || (w_op.funct3 == F3_REM)) &&
                          (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
   assign w_special     = w_op.funct3[2] & (w_b_zero | w_ovf);
   assign w_special_res = w_b_zero ? (w_op.funct3[1] ? a_i : '1)
                                   : (w_op.funct3[1] ? '0  : a_i);

   muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk_i    (clk_i),
      .res_i    (res_i),
      .i_flush  (flush_i),
      .i_start  (w_accept & w_op.is_m & ~w_special),
      .i_funct3 (w_op.funct3),
      .i_a      (a_i),
      .i_b      (b_i),
      .o_last   (w_md_last),
      .o_done   (w_md_done),
      .o_result (w_md_result)
   );
`endif

   always_ff @(posedge clk_i or negedge res_i) begin
      if (!res_i) begin
         r_state  <= S_IDLE;
         r_result <= '0;
         r_tag    <= '0;
         r_illeg  <= 1'b0;
      end else if (flush_i) begin
         r_state  <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tag <= tag_i;
                  if (!w_op.is_m) begin
                     r_state  <= S_DONE;
                     r_result <= w_alu;
                     r_illeg  <= 1'b0;
                  end else begin
`ifdef EXEC_MULDIV_EN
                     r_illeg  <= 1'b0;
                     if (w_special) begin
                        r_state  <= S_DONE;
                        r_result <= w_special_res;
                     end else begin
                        r_state  <= S_CALC;
                     end
`else
                     r_state  <= S_DONE;
                     r_result <= '0;
                     r_illeg  <= 1'b1;
`endif
                  end
               end
            end
`ifdef EXEC_MULDIV_EN
            S_CALC: begin
               if (w_md_last) r_state <= S_FIX;
            end
            S_FIX: begin
               if (w_md_done) begin
                  r_state  <= S_DONE;
                  r_result <= w_md_result;
               end
            end
`endif
            S_DONE: begin
               if (out_ready_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid_o = (r_state == S_DONE);
   assign busy_o      = (r_state != S_IDLE);
   assign result_o    = r_result;
   assign tag_o       = r_tag;
   assign illeg_o     = r_illeg;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// tb_exec_unit: scoreboard bench for exec_unit; expectations come from a reference model.
module tb_exec_unit;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic             clk_i = 1'b0;
   logic             res_i = 1'b0;
   logic             flush_i = 1'b0;
   logic             in_valid_i = 1'b0;
   logic             out_ready_i = 1'b1;
   logic [4:0]       op_i = '0;
   logic [XLEN-1:0]  a_i = '0;
   logic [XLEN-1:0]  b_i = '0;
   logic [TAG_W-1:0] tag_i = '0;
   logic             in_ready_o;
   logic             out_valid_o;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] tag_o;
   logic             illeg_o;
   logic             busy_o;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      logic        illeg;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk_i       (clk_i),
      .res_i       (res_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_i        (op_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .tag_i       (tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .tag_o       (tag_o),
      .illeg_o     (illeg_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] tag);
      exp_t e;
      logic [63:0] sa, sb64, ua, ub, p;
      logic signed [31:0] as_, bs_;
      logic ovf;
      e.tag = tag; e.illeg = 1'b0; e.lat = 1; e.res = '0;
      sa = {{32{a[31]}}, a}; sb64 = {{32{b[31]}}, b};
      ua = {32'h0, a};       ub = {32'h0, b};
      as_ = a; bs_ = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (!op[4]) begin
         case (op[2:0])
            3'd0: e.res = op[3] ? a - b : a + b;
            3'd1: e.res = a << b[4:0];
            3'd2: e.res = (as_ < bs_) ? 32'd1 : 32'd0;
            3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
            3'd4: e.res = a ^ b;
            3'd5: if (op[3]) e.res = as_ >>> b[4:0]; else e.res = a >> b[4:0];
            3'd6: e.res = a | b;
            default: e.res = a & b;
         endcase
      end else begin
`ifdef EXEC_MULDIV_EN
         e.lat = 34;
         case (op[2:0])
            3'd0: begin p = ua * ub;   e.res = p[31:0];  end
            3'd1: begin p = sa * sb64; e.res = p[63:32]; end
            3'd2: begin p = sa * ub;   e.res = p[63:32]; end
            3'd3: begin p = ua * ub;   e.res = p[63:32]; end
            3'd4: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.lat = 1; end
                  else if (ovf) begin e.res = a; e.lat = 1; end
                  else e.res = as_ / bs_;
            3'd5: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.lat = 1; end
                  else e.res = a / b;
            3'd6: if (b == 0) begin e.res = a; e.lat = 1; end
                  else if (ovf) begin e.res = 32'h0; e.lat = 1; end
                  else e.res = as_ % bs_;
            default: if (b == 0) begin e.res = a; e.lat = 1; end
                     else e.res = a % b;
         endcase
`else
         e.illeg = 1'b1;
`endif
      end
      return e;
   endfunction

   // Offers one op, counts edges until out_valid_o, captures outputs, then retires it.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int lat, output logic [31:0] res,
                         output logic [4:0] tg, output logic il, output bit rdy_low);
      op_i = op; a_i = a; b_i = b; tag_i = tag; in_valid_i = 1'b1; out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      lat = 1; rdy_low = 1'b1;
      while (!out_valid_o && lat < 100) begin
         if (in_ready_o) rdy_low = 1'b0;
         @(posedge clk_i); #1;
         lat++;
      end
      if (in_ready_o) rdy_low = 1'b0;
      res = result_o; tg = tag_o; il = illeg_o;
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      res_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      n_chk++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, expected 0", out_valid_o); end
      n_chk++; if (result_o !== '0) begin n_fail++; $display("FAIL reset result: got %h, expected 0", result_o); end
      n_chk++; if (tag_o !== '0) begin n_fail++; $display("FAIL reset tag: got %h, expected 0", tag_o); end
      n_chk++; if (illeg_o !== 1'b0) begin n_fail++; $display("FAIL reset illeg: got %b, expected 0", illeg_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, expected 0", busy_o); end
      res_i = 1'b1;
      @(posedge clk_i); #1;
      n_chk++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b, expected 1", in_ready_o); end
   endtask

   task automatic test_alu();
      logic [4:0]  ops [12] = '{5'h00, 5'h08, 5'h0D, 5'h02, 5'h03, 5'h01,
                                5'h04, 5'h05, 5'h06, 5'h07, 5'h00, 5'h08};
      logic [31:0] va  [12] = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3,
                                32'hA5A5_0F0F, 32'h8000_0000, 32'h1200_0034, 32'hF0F0_FFFF, 32'hFFFF_FFFF, 32'h5};
      logic [31:0] vb  [12] = '{32'h1, 32'h1, 32'h21, 32'h1, 32'h1, 32'h24,
                                32'hFFFF_0000, 32'h1F, 32'h0056_0000, 32'h0FF0_00F0, 32'h1, 32'h9};
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic il; bit rl;
      for (int i = 0; i < 12; i++) begin
         sb.push_back(model(ops[i], va[i], vb[i], 5'(i + 1)));
         run_op(ops[i], va[i], vb[i], 5'(i + 1), lat, r, t, il, rl);
         e = sb.pop_front();
         n_chk++; if (r !== e.res) begin n_fail++; $display("FAIL alu[%0d] result: got %h, expected %h", i, r, e.res); end
         n_chk++; if (t !== e.tag) begin n_fail++; $display("FAIL alu[%0d] tag: got %h, expected %h", i, t, e.tag); end
         n_chk++; if (il !== e.illeg) begin n_fail++; $display("FAIL alu[%0d] illeg: got %b, expected %b", i, il, e.illeg); end
         n_chk++; if (lat != e.lat) begin n_fail++; $display("FAIL alu[%0d] latency: got %0d, expected %0d", i, lat, e.lat); end
      end
   endtask

   task automatic test_muldiv();
      logic [4:0]  ops [16] = '{5'h10, 5'h11, 5'h13, 5'h12, 5'h14, 5'h16, 5'h14, 5'h16,
                                5'h14, 5'h16, 5'h15, 5'h17, 5'h15, 5'h17, 5'h11, 5'h14};
      logic [31:0] va  [16] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7, 32'h7,
                                32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h100, 32'h100,
                                32'h5, 32'h5, 32'h8000_0000, 32'h1234_5678};
      logic [31:0] vb  [16] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'h0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h2, 32'h7, 32'h7,
                                32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_F000};
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic il; bit rl;
      for (int i = 0; i < 16; i++) begin
         sb.push_back(model(ops[i], va[i], vb[i], 5'(16 + i)));
         run_op(ops[i], va[i], vb[i], 5'(16 + i), lat, r, t, il, rl);
         e = sb.pop_front();
         n_chk++; if (r !== e.res) begin n_fail++; $display("FAIL md[%0d] result: got %h, expected %h", i, r, e.res); end
         n_chk++; if (t !== e.tag) begin n_fail++; $display("FAIL md[%0d] tag: got %h, expected %h", i, t, e.tag); end
         n_chk++; if (il !== e.illeg) begin n_fail++; $display("FAIL md[%0d] illeg: got %b, expected %b", i, il, e.illeg); end
         n_chk++; if (lat != e.lat) begin n_fail++; $display("FAIL md[%0d] latency: got %0d, expected %0d", i, lat, e.lat); end
         n_chk++; if (rl !== 1'b1) begin n_fail++; $display("FAIL md[%0d] in_ready while busy: got 1, expected 0", i); end
      end
   endtask

   task automatic test_backpressure();
      exp_t e1, e2;
      sb.push_back(model(5'h00, 32'h5, 32'h6, 5'd9));
      sb.push_back(model(5'h04, 32'hF0, 32'hFF, 5'd3));
      op_i = 5'h00; a_i = 32'h5; b_i = 32'h6; tag_i = 5'd9;
      in_valid_i = 1'b1; out_ready_i = 1'b0;
      @(posedge clk_i); #1;
      op_i = 5'h04; a_i = 32'hF0; b_i = 32'hFF; tag_i = 5'd3;
      e1 = sb.pop_front();
      n_chk++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp first valid: got %b, expected 1", out_valid_o); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         n_chk++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp[%0d] valid held: got %b, expected 1", k, out_valid_o); end
         n_chk++; if (result_o !== e1.res) begin n_fail++; $display("FAIL bp[%0d] result held: got %h, expected %h", k, result_o, e1.res); end
         n_chk++; if (tag_o !== e1.tag) begin n_fail++; $display("FAIL bp[%0d] tag held: got %h, expected %h", k, tag_o, e1.tag); end
         n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp[%0d] in_ready: got %b, expected 0", k, in_ready_o); end
      end
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      n_chk++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp retire valid: got %b, expected 0", out_valid_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp retire busy: got %b, expected 0", busy_o); end
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      e2 = sb.pop_front();
      n_chk++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp next valid: got %b, expected 1", out_valid_o); end
      n_chk++; if (result_o !== e2.res) begin n_fail++; $display("FAIL bp next result: got %h, expected %h", result_o, e2.res); end
      n_chk++; if (tag_o !== e2.tag) begin n_fail++; $display("FAIL bp next tag: got %h, expected %h", tag_o, e2.tag); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_flush();
      bit seen;
      op_i = 5'h10; a_i = 32'hFFFF_FFFF; b_i = 32'h3; tag_i = 5'd4; in_valid_i = 1'b1;
`ifdef EXEC_MULDIV_EN
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
`else
      out_ready_i = 1'b0;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
`endif
      flush_i = 1'b1; in_valid_i = 1'b1;
      op_i = 5'h00; a_i = 32'h1; b_i = 32'h1; tag_i = 5'd7;
      #1;
      n_chk++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush in_ready: got %b, expected 0", in_ready_o); end
      @(posedge clk_i); #1;
      flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush busy: got %b, expected 0", busy_o); end
      n_chk++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush valid: got %b, expected 0", out_valid_o); end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk_i); #1;
         if (out_valid_o) seen = 1'b1;
      end
      n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush late valid: got 1, expected 0"); end
   endtask

   task automatic test_reset_mid();
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic il; bit rl;
      op_i = 5'h00; a_i = 32'h10; b_i = 32'h20; tag_i = 5'h15; in_valid_i = 1'b1; out_ready_i = 1'b0;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      #2 res_i = 1'b0;
      #1;
      n_chk++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid valid: got %b, expected 0", out_valid_o); end
      n_chk++; if (result_o !== '0) begin n_fail++; $display("FAIL rstmid result: got %h, expected 0", result_o); end
      n_chk++; if (tag_o !== '0) begin n_fail++; $display("FAIL rstmid tag: got %h, expected 0", tag_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid busy: got %b, expected 0", busy_o); end
      @(posedge clk_i); #1;
      res_i = 1'b1; out_ready_i = 1'b1;
`ifdef EXEC_MULDIV_EN
      op_i = 5'h11; a_i = 32'h1234; b_i = 32'h5678; tag_i = 5'd2; in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #2 res_i = 1'b0;
      #1;
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstcalc busy: got %b, expected 0", busy_o); end
      n_chk++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstcalc valid: got %b, expected 0", out_valid_o); end
      @(posedge clk_i); #1;
      res_i = 1'b1;
`endif
      sb.push_back(model(5'h08, 32'h100, 32'h1, 5'd30));
      run_op(5'h08, 32'h100, 32'h1, 5'd30, lat, r, t, il, rl);
      e = sb.pop_front();
      n_chk++; if (r !== e.res) begin n_fail++; $display("FAIL rstmid recover result: got %h, expected %h", r, e.res); end
      n_chk++; if (lat != e.lat) begin n_fail++; $display("FAIL rstmid recover latency: got %0d, expected %0d", lat, e.lat); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_muldiv();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
